regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (RegWrite/wraddr/wrdata) between two producers:
  - the pipeline writeback stage, which has priority and cannot be back-pressured;
  - a long-latency result source (mult/div, load return), which uses a valid/ready handshake.
- Buffers long-latency results in a small FIFO.
- Keeps a 32-bit busy scoreboard of registers with pending long-latency results for the hazard unit.
- Raises a stall request when the long-latency path starves.

Parameters:
DEPTH, 2, long-latency result FIFO entries (power of two, >=2)
STARVE_MAX, 4, consecutive blocked cycles before stall_req asserts (>=1)

Ports:
clock      in   1   system clock, rising edge
reset      in   1   asynchronous, active-high
wb_valid   in   1   writeback write request, no handshake
wb_addr    in   5   writeback destination register
wb_data    in   32  writeback data
lu_valid   in   1   long-latency result valid
lu_ready   out  1   FIFO can accept a long-latency result
lu_addr    in   5   long-latency destination register
lu_data    in   32  long-latency result data
iss_valid  in   1   long-latency op issued; reserves iss_addr
iss_addr   in   5   destination register reserved at issue
busy       out  32  per-register pending bit; bit 0 always 0
stall_req  out  1   request upstream to hold writeback
err        out  1   sticky protocol-violation flag
RegWrite   out  1   to register file
wraddr     out  5   to register file
wrdata     out  32  to register file

Behaviour:
- Reset is asynchronous and active-high, on signal reset; clock is clock.
- Reset values:
  - FIFO empty, busy=0, starvation counter=0, stall_req=0, err=0.
  - While reset is high, RegWrite=0 and lu_ready=0, overriding all inputs.
- Handshake and enqueue:
  - lu_ready = (count < DEPTH); it is a function of registered state only, so a full FIFO does not accept in the same cycle it dequeues.
  - A transfer occurs at the rising edge when lu_valid && lu_ready; the entry is pushed to the FIFO tail.
  - lu_addr=0 is accepted and queued like any other entry.
- Write-port selection is combinational from the inputs and FIFO head, evaluated each cycle:
  1. stall_req=1 and FIFO non-empty: the head drains. If wb_valid=1 it is ignored and err sets (sticky until reset).
  2. Otherwise, wb_valid=1 and wb_addr!=0: writeback wins. RegWrite=1, wraddr=wb_addr, wrdata=wb_data.
  3. Otherwise, FIFO non-empty: the head pops at the edge. RegWrite=(head addr!=0), wraddr=head addr, wrdata=head data.
  4. Otherwise RegWrite=0; wraddr/wrdata are don't-care and driven 0.
- Writeback with wb_addr=0 is dropped: RegWrite=0 and the port is free for the FIFO head in that cycle.
- Register 0 is never written (RegWrite stays 0 for addr 0).
- Latency:
  - Writeback reaches the register file at the same edge it is presented.
  - A long-latency result reaches it at the earliest one edge after acceptance, since there is no FIFO bypass.
- Simultaneous push and pop:
  - Allowed when count < DEPTH; count is unchanged.
  - FIFO pointers wrap modulo DEPTH.
- Scoreboard:
  - iss_valid && iss_addr!=0 sets busy[iss_addr] at the edge.
  - A FIFO pop with head addr A!=0 clears busy[A] at the edge.
  - Set and clear of the same bit in the same cycle: set wins.
  - A writeback write never changes busy.
  - busy[0] is hard 0.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and is not popped; it resets to 0 on any pop or when the FIFO is empty.
  - stall_req is registered: it sets at the edge where the counter reaches STARVE_MAX.
  - It clears at the edge where the FIFO becomes empty.
  - While stall_req=1, the FIFO drains one entry per cycle.
- Reset mid-operation: queued results are discarded and busy is cleared; no partial write is issued.

Test Plan:
1. Reset, then wb_valid=1, wb_addr=5, wb_data=0xDEADBEEF for 1 cycle -> same cycle RegWrite=1, wraddr=5, wrdata=0xDEADBEEF; busy=0, lu_ready=1.
2. iss_valid=1, iss_addr=9; 3 cycles later lu_valid=1, lu_addr=9, lu_data=0x1234, wb_valid=0 -> busy[9]=1 from the next edge; RegWrite=1, wraddr=9 one cycle after acceptance; busy[9]=0 after that edge.
3. Fill the FIFO (2 results, addr 3 and 4) while wb_valid=1 continuously with addr 7 -> lu_ready=0 after 2 accepts; stall_req=1 after 4 blocked cycles; the next 2 cycles write r3 then r4 despite wb_valid; err=1; stall_req=0 after the FIFO empties.
4. Same cycle: iss_valid=1, iss_addr=6, and FIFO head addr 6 pops -> busy[6]=1 after the edge (set wins).
5. wb_valid=1, wb_addr=0 with FIFO head addr 2, data 0x55 -> RegWrite=1, wraddr=2, wrdata=0x55 (writeback dropped). Also lu_addr=0 accepted -> popped with RegWrite=0.
6. Assert reset with 2 queued entries and busy[3]=1 -> RegWrite=0, lu_ready=0 during reset; afterwards busy=0, FIFO empty, err=0, lu_ready=1.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the register-file write-port arbiter's producer, scoreboard and
// register-file signals.
//
// Handshake (long-latency path only): a result transfers at the rising edge
// where lu_valid && lu_ready are both high. lu_ready depends on registered
// state only, never on lu_valid. The producer holds lu_addr/lu_data stable
// while lu_valid is high and lu_ready is low. The writeback path has no
// handshake: wb_valid is a request that is either taken or ignored in the
// same cycle.
interface regfile_wr_arbiter_if;
  // Writeback stage
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  // Long-latency result source
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  // Issue-time reservation
  logic        iss_valid;
  logic [4:0]  iss_addr;
  // Hazard / control outputs
  logic [31:0] busy;
  logic        stall_req;
  logic        err;
  // Register file write port
  logic        RegWrite;
  logic [4:0]  wraddr;
  logic [31:0] wrdata;
  // Debug view of the drain state machine (1 = draining)
  logic        dbg_state;

  // Arbiter side
  modport slave (
    input  wb_valid, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    input  iss_valid, iss_addr,
    output lu_ready, busy, stall_req, err,
    output RegWrite, wraddr, wrdata, dbg_state
  );

  // Producer / environment side
  modport master (
    output wb_valid, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    output iss_valid, iss_addr,
    input  lu_ready, busy, stall_req, err,
    input  RegWrite, wraddr, wrdata, dbg_state
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the writeback stage (priority,
// no back-pressure) and a FIFO of long-latency results. It tracks pending
// long-latency destinations in a busy scoreboard and forces a drain when the
// FIFO is starved for too long.
module regfile_wr_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                 clock,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          err_q, err_d;

  logic          empty;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic          lu_ready;
  logic          push;
  logic          pop;
  logic          wb_hit;
  logic          wb_win;
  logic          drain;

  // FIFO status, handshake and write-port arbitration
  always_comb begin
    empty     = (count_q == '0);
    head_addr = addr_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    // Registered state only: a full FIFO cannot accept in the cycle it pops.
    lu_ready  = !reset && (count_q < DEPTH_C);
    push      = bus.lu_valid && lu_ready;
    // A writeback to r0 is dropped, freeing the port for the FIFO head.
    wb_hit    = bus.wb_valid && (bus.wb_addr != 5'd0);
    drain     = (state_q == S_DRAIN) && !empty;
    pop       = !reset && !empty && (drain || !wb_hit);
    wb_win    = !reset && !drain && wb_hit;
  end

  // Register-file port and status outputs
  always_comb begin
    bus.RegWrite  = 1'b0;
    bus.wraddr    = 5'd0;
    bus.wrdata    = 32'd0;
    bus.lu_ready  = lu_ready;
    bus.busy      = busy_q;
    bus.stall_req = (state_q == S_DRAIN);
    bus.err       = err_q;
    bus.dbg_state = state_q;
    if (wb_win) begin
      bus.RegWrite = 1'b1;
      bus.wraddr   = bus.wb_addr;
      bus.wrdata   = bus.wb_data;
    end else if (pop) begin
      bus.RegWrite = (head_addr != 5'd0);
      bus.wraddr   = head_addr;
      bus.wrdata   = head_data;
    end
  end

  // FIFO pointers/occupancy, scoreboard, starvation counter and sticky error
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    err_d    = err_q;
    starve_d = starve_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    // Clear on pop first so a same-cycle reservation of the same register wins.
    if (pop && (head_addr != 5'd0)) busy_d[head_addr] = 1'b0;
    if (bus.iss_valid && (bus.iss_addr != 5'd0)) busy_d[bus.iss_addr] = 1'b1;
    busy_d[0] = 1'b0;

    // Writeback ignored while draining is a protocol violation.
    if (drain && bus.wb_valid) err_d = 1'b1;

    if (empty || pop)              starve_d = '0;
    else if (starve_q != STARVE_C) starve_d = starve_q + 1'b1;
  end

  // Drain state machine: enter after STARVE_MAX blocked cycles, leave when empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (starve_d == STARVE_C) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0)        state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // Control state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_RUN;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= bus.lu_addr;
      data_mem_q[wr_ptr_q] <= bus.lu_data;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized check of regfile_wr_arbiter against a queue-based
// model of the write-port sharing rules.
module tb_regfile_wr_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  // Clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_wr_arbiter_if bus();

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Model state: queued results as {addr, data}
  logic [36:0] exp_q[$];
  logic [31:0] m_busy;
  int          m_starve;
  bit          m_stall;
  bit          m_err;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy   = '0;
    m_starve = 0;
    m_stall  = 0;
    m_err    = 0;
  endtask

  task automatic idle();
    bus.wb_valid  = 0; bus.wb_addr  = '0; bus.wb_data = '0;
    bus.lu_valid  = 0; bus.lu_addr  = '0; bus.lu_data = '0;
    bus.iss_valid = 0; bus.iss_addr = '0;
  endtask

  // One clock: compare at the falling edge, advance the model, return #1 after rise.
  task automatic step();
    int          sz;
    bit          pop;
    bit          accept;
    logic        exp_rw;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    logic [36:0] head;
    @(negedge clock);
    if (reset) begin
      chk("rst_regwrite", bus.RegWrite, 0);
      chk("rst_lu_ready", bus.lu_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_stall", bus.stall_req, 0);
      chk("rst_err", bus.err, 0);
      model_reset();
    end else begin
      sz     = exp_q.size();
      head   = (sz > 0) ? exp_q[0] : '0;
      pop    = 0;
      exp_rw = 0;
      exp_a  = '0;
      exp_d  = '0;
      if (m_stall && sz > 0) pop = 1;
      else if (bus.wb_valid && bus.wb_addr != 0) begin
        exp_rw = 1; exp_a = bus.wb_addr; exp_d = bus.wb_data;
      end else if (sz > 0) pop = 1;
      if (pop) begin
        exp_a  = head[36:32];
        exp_d  = head[31:0];
        exp_rw = (exp_a != 0);
      end
      chk("lu_ready", bus.lu_ready, (sz < DEPTH));
      chk("regwrite", bus.RegWrite, exp_rw);
      chk("wraddr", bus.wraddr, exp_a);
      chk("wrdata", bus.wrdata, exp_d);
      chk("busy", bus.busy, m_busy);
      chk("stall_req", bus.stall_req, m_stall);
      chk("err", bus.err, m_err);
      // Advance model across the rising edge
      if (m_stall && sz > 0 && bus.wb_valid) m_err = 1;
      accept = bus.lu_valid && (sz < DEPTH);
      if (pop) begin
        void'(exp_q.pop_front());
        if (exp_a != 0) m_busy[exp_a] = 1'b0;
      end
      if (bus.iss_valid && bus.iss_addr != 0) m_busy[bus.iss_addr] = 1'b1;
      if (accept) exp_q.push_back({bus.lu_addr, bus.lu_data});
      m_starve = (sz > 0 && !pop) ? m_starve + 1 : 0;
      if (!m_stall && m_starve >= STARVE_MAX) m_stall = 1;
      else if (m_stall && exp_q.size() == 0) m_stall = 0;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    step();
    bus.wb_valid = 1; bus.wb_addr = 5'd5; bus.lu_valid = 1; bus.lu_addr = 5'd3;
    step();                              // outputs held off during reset
    reset = 0;
    idle();

    // 1: writeback goes straight through
    bus.wb_valid = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    step();
    idle();

    // 2: reservation, acceptance, pop one edge later
    bus.iss_valid = 1; bus.iss_addr = 5'd9;
    step();
    idle();
    chk("t2_busy9_set", bus.busy[9], 1);
    step(); step();
    bus.lu_valid = 1; bus.lu_addr = 5'd9; bus.lu_data = 32'h1234;
    step();
    idle();
    chk("t2_busy9_pending", bus.busy[9], 1);
    step();                              // r9 written here
    chk("t2_busy9_clear", bus.busy[9], 0);

    // 3: fill under continuous writeback, starvation forces drain
    bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h7777_0007;
    bus.lu_valid = 1; bus.lu_addr = 5'd3; bus.lu_data = 32'hA3;
    step();
    bus.lu_addr = 5'd4; bus.lu_data = 32'hA4;
    step();
    chk("t3_full", bus.lu_ready, 0);
    bus.lu_valid = 0;
    repeat (7) step();
    chk("t3_err", bus.err, 1);
    chk("t3_stall_off", bus.stall_req, 0);
    idle();

    // 4: reservation and pop of the same register in one cycle
    bus.lu_valid = 1; bus.lu_addr = 5'd6; bus.lu_data = 32'h66;
    step();
    idle();
    bus.iss_valid = 1; bus.iss_addr = 5'd6;
    step();
    idle();
    chk("t4_set_wins", bus.busy[6], 1);

    // 5: writeback to r0 yields the port; r0 result pops silently
    bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h70;
    bus.lu_valid = 1; bus.lu_addr = 5'd2; bus.lu_data = 32'h55;
    step();
    bus.wb_addr = 5'd0; bus.wb_data = 32'hBAD0;
    bus.lu_addr = 5'd0; bus.lu_data = 32'h0F0F;
    step();
    idle();
    step();
    step();

    // 6: reset with queued entries and a pending reservation
    bus.iss_valid = 1; bus.iss_addr = 5'd3;
    step();
    idle();
    bus.wb_valid = 1; bus.wb_addr = 5'd7; bus.wb_data = 32'h71;
    bus.lu_valid = 1; bus.lu_addr = 5'd3; bus.lu_data = 32'h33;
    step();
    bus.lu_addr = 5'd8; bus.lu_data = 32'h88;
    step();
    chk("t6_busy3", bus.busy[3], 1);
    reset = 1;
    step();
    step();
    reset = 0;
    idle();
    step();
    chk("t6_busy_clear", bus.busy, 0);
    chk("t6_ready", bus.lu_ready, 1);
    chk("t6_err_clear", bus.err, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.wb_valid  = ($urandom_range(0, 99) < 55);
      bus.wb_addr   = 5'($urandom_range(0, 31));
      bus.wb_data   = $urandom;
      bus.lu_valid  = ($urandom_range(0, 99) < 45);
      bus.lu_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.lu_data   = $urandom;
      bus.iss_valid = ($urandom_range(0, 99) < 30);
      bus.iss_addr  = 5'($urandom_range(0, 31));
      if (i == 200) reset = 1;
      if (i == 202) reset = 0;
      step();
    end
    idle();
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
